tft_pixel_stream_adapter: RTL and testbench
===========================================

// Module: tft_pixel_stream_adapter
// PURPOSE
//  Upstream feeder for the ILI9341 8080-I driver.
//  - Accepts an RGB565 valid/ready stream with a start-of-frame flag and buffers it in a small FIFO.
//  - Drives the driver's pixelDataIn/dataReady and tracks the driver's pixelAddr to pop pixels.
//  - Asserts newFrameStrobe when the stream resynchronises mid-frame.
//  - Runs on the driver clock (slowClk); it does not cross clock domains.
// PARAMETERS
//  DEPTH                  16     FIFO entries; power of 2, >=4
//  NUM_PIXELS             76800  pixels per frame (320x240)
//  NUM_FRAME_START_PARAMS 12     last header address the driver emits before pixel data
// PORTS
//  clk             in   1   clock, rising edge (driver slowClk)
//  reset           in   1   reset, asynchronous, active-high
//  s_data          in   16  RGB565 pixel from the producer
//  s_sof           in   1   s_data is the first pixel of a frame
//  s_valid         in   1   producer has a pixel
//  s_ready         out  1   adapter accepts the pixel (transfer = s_valid & s_ready)
//  pixelAddr       in   17  driver address output
//  pixelDataIn     out  16  pixel presented to the driver
//  dataReady       out  1   head pixel is valid for the driver to send
//  newFrameStrobe  out  1   one-cycle pulse; forces the driver to restart the frame
//  frame_active    out  1   high in STREAM
//  drop_count      out  16  saturating count of discarded pixels
//  underrun        out  1   one-cycle pulse; STREAM, pix_cnt!=0, FIFO empty
// BEHAVIOUR
//  Reset:
//   - While reset is high: s_ready=0, dataReady=0, newFrameStrobe=0, frame_active=0,
//     drop_count=0, underrun=0, pixelDataIn=0.
//   - Pointers, count and pix_cnt clear; state=WAIT_HDR; addr_q=0; strobe_d=0.
//   - Reset asserted mid-frame discards FIFO contents.
//  FIFO:
//   - Each entry is {sof,data}, 17 bits. s_ready = !full, derived from the registered count.
//   - Push and pop in the same cycle leave count unchanged. Pop never occurs when empty.
//   - pixelDataIn = head data when not empty, else 0. The head is a combinational read.
//  Address tracking:
//   - addr_q <= pixelAddr every cycle.
//   - adv = (pixelAddr == addr_q+1).
//   - hdr_end = (addr_q == NUM_FRAME_START_PARAMS) & (pixelAddr == 0) & !strobe_d.
//   - strobe_d is newFrameStrobe delayed by one cycle.
//  FSM (enum tft_adapt_state_t):
//   WAIT_HDR:
//    - dataReady=0.
//    - If head is non-SOF, pop it (one per cycle) and increment drop_count.
//    - On hdr_end: go to STREAM with pix_cnt=0.
//   STREAM:
//    - dataReady = !empty & !(head.sof & pix_cnt!=0).
//    - If pix_cnt==0 and head is non-SOF: pop it, drop_count++, dataReady=0.
//    - If adv: pop the head and pix_cnt++.
//    - If adv and pix_cnt==NUM_PIXELS-1: pop, then WAIT_HDR with pix_cnt=0.
//    - If head.sof and pix_cnt!=0: go to RESYNC without popping.
//   RESYNC:
//    - newFrameStrobe=1 for exactly one cycle; next state WAIT_HDR; pix_cnt=0.
//  Latency and ordering:
//   - Pop occurs the cycle after the driver's address advance; the next head is visible in that cycle.
//   - The driver does not sample the next pixel for two more slowClk cycles.
//  Width rules:
//   - pix_cnt is 17 bits.
//   - drop_count saturates at 16'hFFFF.
//  Boundary cases:
//   - Full FIFO: s_ready=0 and no data is lost.
//   - Empty FIFO in STREAM: dataReady=0 and the driver stalls.
//   - An address advance while the FIFO is empty is not a pop.
//   - SOF arriving exactly at the end of a frame is the normal case; no strobe.
// STRUCTURE
//  - Package tft_pkg: tft_adapt_state_t, NUM_PIXELS, NUM_FRAME_START_PARAMS and the
//    RGB565 typedef, shared with the driver.
//  - Sub-module sync_fifo #(WIDTH=17, DEPTH) provides push/pop/full/empty/count.
//    The adapter holds the FSM, address tracking and counters.
// TESTING
//  1. Reset, then pixelAddr sequence 0..12 ->0 with a 3-pixel SOF frame queued (NUM_PIXELS=3).
//     -> frame_active=1; 3 pops on advances 0->1->2->3; then WAIT_HDR.
//  2. Two non-SOF pixels pushed before a SOF.
//     -> drop_count=2; the SOF pixel is presented first.
//  3. FIFO empty during STREAM at pix_cnt=1, then driver advance.
//     -> dataReady=0, underrun pulses, no pop, pix_cnt holds.
//  4. SOF at head while pix_cnt=1.
//     -> newFrameStrobe high for 1 cycle; a forced 12->0 address in the next cycle does not arm;
//        a later 12->0 arms.
//  5. Push 16 pixels with no pops.
//     -> s_ready=0 after 16; the 17th s_valid stalls until the first pop.
//  6. Reset asserted mid-STREAM with 5 entries.
//     -> outputs cleared immediately; count=0; WAIT_HDR.

Source files
------------

// File: rtl/tft_pkg.sv
// Shared types and frame geometry for the ILI9341 pixel path (adapter and driver).
// Latency: none; declarations only.
// Backpressure: not applicable.
package tft_pkg;

  // Pixels in one 320x240 frame.
  localparam int NUM_PIXELS = 76800;

  // Last header address the driver emits before it starts on pixel data.
  localparam int NUM_FRAME_START_PARAMS = 12;

  // RGB565 pixel layout, matching the driver's pixelDataIn bit order.
  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // Adapter frame-tracking state.
  typedef enum logic [1:0] {
    WAIT_HDR = 2'd0,
    STREAM   = 2'd1,
    RESYNC   = 2'd2
  } tft_adapt_state_t;

  // One FIFO slot: the start-of-frame marker travels with its pixel.
  typedef struct packed {
    logic    sof;
    rgb565_t data;
  } tft_fifo_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head read (first-word fall-through).
// Latency: a pushed word is visible at rdata_o the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  // Flags come straight from the registered count so they are glitch-free.
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave the count alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/tft_pixel_stream_adapter.sv
// Buffers an RGB565 SOF-tagged stream and feeds the ILI9341 driver, popping on each pixelAddr advance.
// Latency: a pixel reaches pixelDataIn one cycle after its push; pops land the cycle after an address advance.
// Backpressure: s_ready drops when the FIFO is full; dataReady drops (driver stalls) when the FIFO is empty.
module tft_pixel_stream_adapter #(
  parameter int DEPTH                  = 16,
  parameter int NUM_PIXELS             = tft_pkg::NUM_PIXELS,
  parameter int NUM_FRAME_START_PARAMS = tft_pkg::NUM_FRAME_START_PARAMS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] s_data,
  input  logic        s_sof,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [16:0] pixelAddr,
  output logic [15:0] pixelDataIn,
  output logic        dataReady,
  output logic        newFrameStrobe,
  output logic        frame_active,
  output logic [15:0] drop_count,
  output logic        underrun
);

  import tft_pkg::*;

  localparam logic [16:0] LAST_PIX = 17'(NUM_PIXELS - 1);
  localparam logic [16:0] HDR_LAST = 17'(NUM_FRAME_START_PARAMS);

  // Registered state
  tft_adapt_state_t state_q;
  logic [16:0]      addr_q;
  logic [16:0]      pix_cnt_q;
  logic [15:0]      drop_count_q;
  logic             strobe_dly_q;
  logic             underrun_lvl_q;
  logic             underrun_q;

  // FIFO interface
  tft_fifo_entry_t      push_entry;
  tft_fifo_entry_t      head;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;

  // Decode
  logic adv;
  logic hdr_end;
  logic resync_req;
  logic data_ready;
  logic drop;
  logic underrun_cond;

  assign push_entry.sof  = s_sof;
  assign push_entry.data = s_data;

  // Hold off the producer during reset as well as when full.
  assign s_ready   = !fifo_full && !reset;
  assign fifo_push = s_valid && s_ready;

  sync_fifo #(
    .WIDTH ($bits(tft_fifo_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .wdata_i (push_entry),
    .pop_i   (fifo_pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Driver-facing outputs.
  assign pixelDataIn    = fifo_empty ? 16'h0000 : head.data;
  assign dataReady      = data_ready;
  assign newFrameStrobe = (state_q == RESYNC);
  assign frame_active   = (state_q == STREAM);
  assign drop_count     = drop_count_q;
  assign underrun       = underrun_q;

  // Mid-frame starvation: the driver would stall waiting on us.
  assign underrun_cond = (state_q == STREAM) && (pix_cnt_q != '0) && (fifo_count == '0);

  // Address tracking and pop/drop selection for the current head.
  always_comb begin
    adv        = (pixelAddr == addr_q + 17'd1);
    // The driver re-walks its header right after a strobe; ignore the first 12->0 it produces.
    hdr_end    = (addr_q == HDR_LAST) && (pixelAddr == 17'd0) && !strobe_dly_q;
    resync_req = (state_q == STREAM) && !fifo_empty && head.sof && (pix_cnt_q != '0);
    data_ready = 1'b0;
    fifo_pop   = 1'b0;
    drop       = 1'b0;
    unique case (state_q)
      WAIT_HDR: begin
        // Anything before the next SOF belongs to a frame we never started.
        if (!fifo_empty && !head.sof) begin
          fifo_pop = 1'b1;
          drop     = 1'b1;
        end
      end
      STREAM: begin
        if (!fifo_empty) begin
          if (!head.sof && (pix_cnt_q == '0)) begin
            // First pixel of a frame must carry SOF; discard until it does.
            fifo_pop = 1'b1;
            drop     = 1'b1;
          end else if (!resync_req) begin
            data_ready = 1'b1;
            fifo_pop   = adv;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Frame FSM, pixel counter, drop counter and registered status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= WAIT_HDR;
      addr_q         <= '0;
      pix_cnt_q      <= '0;
      drop_count_q   <= '0;
      strobe_dly_q   <= 1'b0;
      underrun_lvl_q <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      addr_q         <= pixelAddr;
      strobe_dly_q   <= newFrameStrobe;
      underrun_lvl_q <= underrun_cond;
      underrun_q     <= underrun_cond && !underrun_lvl_q;

      if (drop && (drop_count_q != 16'hFFFF)) begin
        drop_count_q <= drop_count_q + 16'd1;
      end

      case (state_q)
        WAIT_HDR: begin
          pix_cnt_q <= '0;
          if (hdr_end) begin
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (resync_req) begin
            state_q   <= RESYNC;
            pix_cnt_q <= '0;
          end else if (data_ready && adv) begin
            if (pix_cnt_q == LAST_PIX) begin
              state_q   <= WAIT_HDR;
              pix_cnt_q <= '0;
            end else begin
              pix_cnt_q <= pix_cnt_q + 17'd1;
            end
          end
        end
        RESYNC: begin
          state_q   <= WAIT_HDR;
          pix_cnt_q <= '0;
        end
        default: begin
          state_q   <= WAIT_HDR;
          pix_cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tft_pixel_stream_adapter.sv
// Self-checking bench for tft_pixel_stream_adapter with a 3-pixel frame.
// Latency: inputs change 2 ns after each rising edge; outputs are sampled at the same point.
// Backpressure: the producer model waits on s_ready with a bounded cycle budget.
module tb_tft_pixel_stream_adapter;

  localparam int NPIX = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] s_data;
  logic        s_sof;
  logic        s_valid;
  logic        s_ready;
  logic [16:0] pixelAddr;
  logic [15:0] pixelDataIn;
  logic        dataReady;
  logic        newFrameStrobe;
  logic        frame_active;
  logic [15:0] drop_count;
  logic        underrun;

  int tests = 0;
  int fails = 0;
  logic [15:0] sb[$];

  typedef struct {
    logic [16:0] addr;
    logic        act;
    logic        dr;
    logic [15:0] data;
  } vec_t;
  vec_t vecs[18];

  localparam logic [15:0] PA = 16'hF800, PB = 16'h07E0, PC = 16'h001F;

  always #5 clk = ~clk;

  tft_pixel_stream_adapter #(
    .DEPTH(16), .NUM_PIXELS(NPIX), .NUM_FRAME_START_PARAMS(12)
  ) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_sof(s_sof), .s_valid(s_valid),
    .s_ready(s_ready), .pixelAddr(pixelAddr), .pixelDataIn(pixelDataIn),
    .dataReady(dataReady), .newFrameStrobe(newFrameStrobe), .frame_active(frame_active),
    .drop_count(drop_count), .underrun(underrun)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Producer: present one pixel and hold it until accepted (bounded).
  task automatic push_pix(input logic sof, input logic [15:0] d, input bit present);
    int n;
    n = 0;
    s_valid = 1'b1; s_sof = sof; s_data = d;
    while (!s_ready && n < 50) begin
      tick();
      n++;
    end
    chk("push_accept_in_time", 32'(n < 50), 32'd1);
    tick();
    s_valid = 1'b0;
    if (present) sb.push_back(d);
  endtask

  // Driver: advance pixelAddr by one; when a pixel is due, it must match the scoreboard.
  task automatic advance(input bit exp_dr);
    logic [15:0] e;
    chk("adv_dataReady", 32'(dataReady), 32'(exp_dr));
    if (exp_dr) begin
      if (sb.size() == 0) begin
        chk("adv_scoreboard_nonempty", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("adv_pixel", 32'(pixelDataIn), 32'(e));
      end
    end
    pixelAddr = pixelAddr + 17'd1;
    tick();
  endtask

  // Driver: header walk 0..12 then back to 0 for the first pixel.
  task automatic run_header();
    for (int a = 0; a <= 12; a++) begin
      pixelAddr = 17'(a);
      tick();
    end
    pixelAddr = 17'd0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] prev_addr;
    logic        prev_dr;

    for (int i = 0; i <= 12; i++) vecs[i] = '{17'(i), 1'b0, 1'b0, PA};
    vecs[13] = '{17'd0, 1'b1, 1'b1, PA};
    vecs[14] = '{17'd1, 1'b1, 1'b1, PB};
    vecs[15] = '{17'd2, 1'b1, 1'b1, PC};
    vecs[16] = '{17'd3, 1'b0, 1'b0, 16'h0000};
    vecs[17] = '{17'd3, 1'b0, 1'b0, 16'h0000};

    reset = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_data = '0; pixelAddr = '0;
    repeat (3) tick();
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_dataReady", 32'(dataReady), 32'd0);
    chk("rst_strobe", 32'(newFrameStrobe), 32'd0);
    chk("rst_frame_active", 32'(frame_active), 32'd0);
    chk("rst_drop_count", 32'(drop_count), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_pixelDataIn", 32'(pixelDataIn), 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_s_ready", 32'(s_ready), 32'd1);

    // 1: one 3-pixel frame driven from the vector table
    push_pix(1'b1, PA, 1'b1);
    push_pix(1'b0, PB, 1'b1);
    push_pix(1'b0, PC, 1'b1);
    prev_addr = pixelAddr;
    prev_dr   = 1'b0;
    for (int i = 0; i < 18; i++) begin
      if (vecs[i].addr == prev_addr + 17'd1 && prev_dr) begin
        if (sb.size() != 0) chk("t1_sb_pixel", 32'(pixelDataIn), 32'(sb.pop_front()));
        else chk("t1_sb_nonempty", 32'(sb.size()), 32'd1);
      end
      pixelAddr = vecs[i].addr;
      tick();
      chk($sformatf("t1_active[%0d]", i), 32'(frame_active), 32'(vecs[i].act));
      chk($sformatf("t1_dr[%0d]", i), 32'(dataReady), 32'(vecs[i].dr));
      chk($sformatf("t1_data[%0d]", i), 32'(pixelDataIn), 32'(vecs[i].data));
      chk($sformatf("t1_strobe[%0d]", i), 32'(newFrameStrobe), 32'd0);
      prev_addr = vecs[i].addr;
      prev_dr   = vecs[i].dr;
    end

    // 2: stale non-SOF pixels ahead of a SOF are dropped
    push_pix(1'b0, 16'h1111, 1'b0);
    push_pix(1'b0, 16'h2222, 1'b0);
    push_pix(1'b1, 16'hD0D0, 1'b1);
    push_pix(1'b0, 16'hE0E0, 1'b1);
    push_pix(1'b0, 16'hF0F0, 1'b1);
    chk("t2_drop_count", 32'(drop_count), 32'd2);
    chk("t2_head_is_sof", 32'(pixelDataIn), 32'h0000D0D0);
    run_header();
    chk("t2_active", 32'(frame_active), 32'd1);
    advance(1'b1); advance(1'b1); advance(1'b1);
    chk("t2_frame_done", 32'(frame_active), 32'd0);

    // 3: underrun mid-frame; an advance on an empty FIFO is not a pop
    push_pix(1'b1, 16'h6060, 1'b1);
    run_header();
    advance(1'b1);
    chk("t3_dr_empty", 32'(dataReady), 32'd0);
    chk("t3_underrun_before", 32'(underrun), 32'd0);
    tick();
    chk("t3_underrun_pulse", 32'(underrun), 32'd1);
    tick();
    chk("t3_underrun_one_cycle", 32'(underrun), 32'd0);
    advance(1'b0);
    chk("t3_still_active", 32'(frame_active), 32'd1);
    push_pix(1'b0, 16'h7070, 1'b1);
    advance(1'b1);
    chk("t3_pix_cnt_held", 32'(frame_active), 32'd1);
    push_pix(1'b0, 16'h8080, 1'b1);
    advance(1'b1);
    chk("t3_frame_done", 32'(frame_active), 32'd0);

    // 4: SOF at head mid-frame forces a resync
    push_pix(1'b1, 16'h9090, 1'b1);
    push_pix(1'b1, 16'hA0A0, 1'b1);
    run_header();
    advance(1'b1);
    chk("t4_dr_blocked", 32'(dataReady), 32'd0);
    chk("t4_strobe_low", 32'(newFrameStrobe), 32'd0);
    pixelAddr = 17'd12;
    tick();
    chk("t4_strobe_high", 32'(newFrameStrobe), 32'd1);
    chk("t4_inactive", 32'(frame_active), 32'd0);
    tick();
    chk("t4_strobe_one_cycle", 32'(newFrameStrobe), 32'd0);
    pixelAddr = 17'd0;
    tick();
    chk("t4_forced_hdr_no_arm", 32'(frame_active), 32'd0);
    run_header();
    chk("t4_rearm", 32'(frame_active), 32'd1);
    chk("t4_sof_presented", 32'(pixelDataIn), 32'h0000A0A0);
    for (int i = 0; i < 4; i++) push_pix(1'b0, 16'(16'hB000 + i), 1'b0);
    chk("t4_dr_ready", 32'(dataReady), 32'd1);

    // 6: reset mid-STREAM with 5 entries
    #1 reset = 1'b1;
    #1;
    chk("t6_s_ready", 32'(s_ready), 32'd0);
    chk("t6_dataReady", 32'(dataReady), 32'd0);
    chk("t6_pixelDataIn", 32'(pixelDataIn), 32'd0);
    chk("t6_frame_active", 32'(frame_active), 32'd0);
    chk("t6_drop_count", 32'(drop_count), 32'd0);
    sb.delete();
    tick();
    reset = 1'b0;
    pixelAddr = 17'd0;
    tick();
    chk("t6_post_s_ready", 32'(s_ready), 32'd1);
    chk("t6_post_empty", 32'(pixelDataIn), 32'd0);
    chk("t6_post_wait_hdr", 32'(frame_active), 32'd0);

    // 5: fill to 16; the 17th waits for the first pop and is not lost
    for (int i = 0; i < 16; i++) push_pix(i == 0, 16'(16'h1000 + i), i < 3);
    chk("t5_full", 32'(s_ready), 32'd0);
    s_valid = 1'b1; s_sof = 1'b0; s_data = 16'hBEEF;
    repeat (3) tick();
    chk("t5_stall", 32'(s_ready), 32'd0);
    run_header();
    chk("t5_stall_hdr", 32'(s_ready), 32'd0);
    chk("t5_active", 32'(frame_active), 32'd1);
    advance(1'b1);
    chk("t5_ready_after_pop", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
    chk("t5_full_again", 32'(s_ready), 32'd0);
    advance(1'b1);
    advance(1'b1);
    chk("t5_frame_done", 32'(frame_active), 32'd0);
    repeat (20) tick();
    chk("t5_drop_count", 32'(drop_count), 32'd14);
    chk("t5_drained", 32'(pixelDataIn), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
